// File: rtl/dcf_signal_gen.sv
// rtl/dcf_signal_gen.sv - DCF77 amplitude-keyed 77.5 kHz carrier generator
// Defining DCF_PULSE_PORT_EN exposes the internal pulse register as an output port.
module dcf_signal_gen #(
   parameter int          CLK_FREQ     = 1300000,
   parameter logic [31:0] PHASE_INC    = 32'd256046128,
   parameter int          REDUCE_SHIFT = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [58:0]        time_data,
   output logic signed [15:0] signal
`ifdef DCF_PULSE_PORT_EN
   ,
   output logic               pulse
`endif
);
   localparam int            CW       = $clog2(CLK_FREQ);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLK_FREQ - 1);
   localparam logic [CW-1:0] DUR_ZERO = CW'(CLK_FREQ / 10);
   localparam logic [CW-1:0] DUR_ONE  = CW'(CLK_FREQ / 5);

`ifndef DCF_PULSE_PORT_EN
   logic pulse;
`endif
   logic [CW-1:0]      cyc;
   logic [5:0]         sec;
   logic [31:0]        phase;
   logic [58:0]        tele;
   logic               started;

   logic [58:0]        cur_tele;
   logic [63:0]        tele_pad;
   logic [5:0]         bit_idx;
   logic [CW-1:0]      dur;
   logic               reduce;
   logic               cyc_end;
   logic               min_end;
   logic [6:0]         q_idx;
   logic [15:0]        mag;
   logic signed [15:0] sine;

   // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64 inclusive.
   function automatic logic [15:0] qsine(input logic [6:0] k);
      logic [15:0] v;
      case (k)
         7'd0:  v = 16'd0;     7'd1:  v = 16'd804;   7'd2:  v = 16'd1608;  7'd3:  v = 16'd2410;  7'd4:  v = 16'd3212;
         7'd5:  v = 16'd4011;  7'd6:  v = 16'd4808;  7'd7:  v = 16'd5602;  7'd8:  v = 16'd6393;  7'd9:  v = 16'd7179;
         7'd10: v = 16'd7962;  7'd11: v = 16'd8739;  7'd12: v = 16'd9512;  7'd13: v = 16'd10278; 7'd14: v = 16'd11039;
         7'd15: v = 16'd11793; 7'd16: v = 16'd12539; 7'd17: v = 16'd13279; 7'd18: v = 16'd14010; 7'd19: v = 16'd14732;
         7'd20: v = 16'd15446; 7'd21: v = 16'd16151; 7'd22: v = 16'd16846; 7'd23: v = 16'd17530; 7'd24: v = 16'd18204;
         7'd25: v = 16'd18868; 7'd26: v = 16'd19519; 7'd27: v = 16'd20159; 7'd28: v = 16'd20787; 7'd29: v = 16'd21403;
         7'd30: v = 16'd22005; 7'd31: v = 16'd22594; 7'd32: v = 16'd23170; 7'd33: v = 16'd23731; 7'd34: v = 16'd24279;
         7'd35: v = 16'd24811; 7'd36: v = 16'd25329; 7'd37: v = 16'd25832; 7'd38: v = 16'd26319; 7'd39: v = 16'd26790;
         7'd40: v = 16'd27245; 7'd41: v = 16'd27683; 7'd42: v = 16'd28105; 7'd43: v = 16'd28510; 7'd44: v = 16'd28898;
         7'd45: v = 16'd29268; 7'd46: v = 16'd29621; 7'd47: v = 16'd29956; 7'd48: v = 16'd30273; 7'd49: v = 16'd30571;
         7'd50: v = 16'd30852; 7'd51: v = 16'd31113; 7'd52: v = 16'd31356; 7'd53: v = 16'd31580; 7'd54: v = 16'd31785;
         7'd55: v = 16'd31971; 7'd56: v = 16'd32137; 7'd57: v = 16'd32285; 7'd58: v = 16'd32412; 7'd59: v = 16'd32521;
         7'd60: v = 16'd32609; 7'd61: v = 16'd32678; 7'd62: v = 16'd32728; 7'd63: v = 16'd32757; 7'd64: v = 16'd32767;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

   // On the very first edge the telegram is latched and used in the same cycle.
   always_comb begin
      cur_tele = started ? tele : time_data;
      tele_pad = {5'd0, cur_tele};
      bit_idx  = 6'd58 - sec;
      dur      = tele_pad[bit_idx] ? DUR_ONE : DUR_ZERO;
      reduce   = (sec != 6'd59) && (cyc < dur);
      cyc_end  = (cyc == CYC_LAST);
      min_end  = cyc_end && (sec == 6'd59);
   end

   always_comb begin
      q_idx = phase[30] ? (7'd64 - {1'b0, phase[29:24]}) : {1'b0, phase[29:24]};
      mag   = qsine(q_idx);
      sine  = phase[31] ? -$signed(mag) : $signed(mag);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cyc     <= '0;
         sec     <= '0;
         phase   <= '0;
         tele    <= '0;
         started <= 1'b0;
         pulse   <= 1'b0;
         signal  <= '0;
      end else begin
         started <= 1'b1;
         if (!started || min_end)
            tele <= time_data;
         cyc <= cyc_end ? '0 : cyc + CW'(1);
         if (cyc_end)
            sec <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
         phase  <= phase + PHASE_INC;
         pulse  <= reduce;
         signal <= reduce ? (sine >>> REDUCE_SHIFT) : sine;
      end
   end
endmodule

// File: tb/tb_dcf_signal_gen.sv
// tb/tb_dcf_signal_gen.sv - self-checking bench for dcf_signal_gen with a scaled second length
module tb_dcf_signal_gen;
   localparam int          CLK     = 600;
   localparam int          MIN_CYC = 60 * CLK;
   localparam logic [31:0] PINC    = 32'd256046128;
   localparam int          RS      = 2;
   localparam logic [58:0] DEF_TELE =
      59'b01001011001110100100100100001000000011101010000010101010001;

   logic               clock;
   logic               reset_n;
   logic [58:0]        time_data;
   logic signed [15:0] signal;
`ifdef DCF_PULSE_PORT_EN
   logic               pulse_port;
`endif

   dcf_signal_gen #(.CLK_FREQ(CLK), .PHASE_INC(PINC), .REDUCE_SHIFT(RS)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .time_data (time_data),
`ifdef DCF_PULSE_PORT_EN
      .pulse     (pulse_port),
`endif
      .signal    (signal)
   );

   int total = 0;
   int bad   = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         if (bad <= 20)
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int sin_ref(input int k);
      real r;
      r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 256.0);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   // Model: expected outputs after edge n, where n counts edges since reset release.
   int          n = 0;
   bit          mvalid = 0;
   int          e_idx;
   int          e_sig;
   bit          e_pulse;
   logic [58:0] m_tele;

   always @(posedge clock) begin
      int          sec_m, cyc_m, dur_m, s;
      logic [31:0] nn, ph;
      if (!reset_n) begin
         n      = 0;
         mvalid = 0;
      end else begin
         if (n % MIN_CYC == 0)
            m_tele = time_data;
         sec_m = (n / CLK) % 60;
         cyc_m = n % CLK;
         dur_m = (sec_m < 59 && m_tele[58 - sec_m]) ? CLK / 5 : CLK / 10;
         e_pulse = (sec_m != 59) && (cyc_m < dur_m);
         nn = n;
         ph = nn * PINC;
         s  = sin_ref(int'(ph[31:24]));
         e_sig  = e_pulse ? $rtoi($floor(s / real'(1 << RS))) : s;
         e_idx  = n;
         mvalid = 1;
         n++;
      end
   end

   int win[$];

   always @(negedge clock) begin
      int got, a, mx;
      if (mvalid) begin
         got = signal;
         check("signal", got, e_sig);
         check("pulse", dut.pulse, e_pulse);
         check("not_min", (got == -32768), 0);
`ifdef DCF_PULSE_PORT_EN
         check("pulse_port", pulse_port, dut.pulse);
`endif
         case (e_idx)
            59:    check("bit0_last_high", dut.pulse, 1);
            60:    check("bit0_first_low", dut.pulse, 0);
            1259:  check("sec2_last_high", dut.pulse, 1);
            1260:  check("midmin_change_ignored", dut.pulse, 0);
            11999: check("sec19_end_low", dut.pulse, 0);
            12000: check("bit1_start", dut.pulse, 1);
            12119: check("bit1_last_high", dut.pulse, 1);
            12120: check("bit1_first_low", dut.pulse, 0);
            35400: check("minmark_start_low", dut.pulse, 0);
            35999: begin
               check("minmark_end_low", dut.pulse, 0);
               check("wrap_sec", dut.sec, 0);
               check("wrap_cyc", dut.cyc, 0);
            end
            36119: check("new_tele_last_high", dut.pulse, 1);
            36120: check("new_tele_first_low", dut.pulse, 0);
            default: ;
         endcase
         if (e_idx >= 35400 && e_idx <= 35999) begin
            a = (got < 0) ? -got : got;
            win.push_back(a);
            if (win.size() > 17)
               void'(win.pop_front());
            if (win.size() == 17) begin
               mx = 0;
               foreach (win[i]) if (win[i] > mx) mx = win[i];
               check("peak17", (mx >= 32000 && mx <= 32767), 1);
            end
         end
         if (e_pulse)
            check("reduced_amp", ((got <= 8192) && (got >= -8192)), 1);
      end
   end

   initial begin
      reset_n   = 1'b0;
      time_data = DEF_TELE;
      check("sin_ref_q1", sin_ref(64), 32767);
      check("sin_ref_45", sin_ref(32), 23170);
      check("sin_ref_q3", sin_ref(192), -32767);
      check("sin_ref_k3", sin_ref(3), 2410);
      repeat (3) @(negedge clock);
      check("reset_signal", signal, 0);
      check("reset_pulse", dut.pulse, 0);
      reset_n = 1'b1;
      repeat (300) @(negedge clock);
      #1 reset_n = 1'b0;
      #1;
      check("async_reset_signal", signal, 0);
      check("async_reset_pulse", dut.pulse, 0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (1000) @(negedge clock);
      time_data = '1;
      repeat (35300) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dcf_signal_gen.md
DCF_SIGNAL_GEN -- requirements
Module: dcf_signal_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 1300000: clock cycles per one-second DCF77 slot.
REQ-002 SHALL have parameter PHASE_INC, default 256046128: 32-bit NCO increment, giving 77.5 kHz at 1.3 MHz.
REQ-003 SHALL have parameter REDUCE_SHIFT, default 2: arithmetic right-shift applied to the carrier during amplitude reduction.
REQ-004 SHALL have port: clock  input  1  single rising-edge clock, 1.3 MHz nominal.
REQ-005 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: time_data  input  59  DCF77 minute telegram; second n is encoded by time_data[58-n].
REQ-007 SHALL have port: signal  output  16 signed  registered sampled carrier, two's complement.
REQ-008 SHALL have an internal register named pulse (1 bit), high while the carrier is reduced, reachable hierarchically as dcf_signal_gen.pulse.

Function
REQ-009 SHALL keep a cycle counter cyc (0..CLK_FREQ-1) and a second counter sec (0..59); cyc wraps to 0 after CLK_FREQ-1 and increments sec; sec wraps from 59 to 0.
REQ-010 SHALL latch time_data into an internal 59-bit register on the edge where sec wraps 59->0 and on the first clock edge after reset release; time_data changes mid-minute SHALL NOT affect the current minute.
REQ-011 SHALL set duration dur = CLK_FREQ/10 (130000) when the latched bit for sec is 0 and CLK_FREQ/5 (260000) when it is 1.
REQ-012 SHALL register pulse = (sec != 59) && (cyc < dur), evaluated from the counter state before the edge; second 59 is the minute mark and carries no reduction.
REQ-013 SHALL advance a 32-bit phase accumulator by PHASE_INC every cycle, wrapping modulo 2^32.
REQ-014 SHALL derive the carrier from phase[31:24] through a 256-entry sine table: entry k = round(32767*sin(2*pi*k/256)). A quarter-wave, 64-entry implementation with symmetry is allowed if its results are bit-identical.
REQ-015 SHALL register signal = sine when the same-cycle reduction condition is false, and sine >>> REDUCE_SHIFT (arithmetic shift) when it is true; signal and pulse SHALL update on the same edge with 1-cycle latency.
REQ-016 SHALL never output -32768.

Reset
REQ-017 SHALL, while reset_n is low, asynchronously force signal=0, pulse=0, cyc=0, sec=0, phase=0 and the latched telegram to 0.
REQ-018 SHALL, when reset is asserted mid-second, abandon the minute; after release, timing restarts at sec 0, cyc 0 with a fresh time_data latch.

Configuration
REQ-019 SHALL, when DCF_PULSE_PORT_EN is defined, add output port pulse (1 bit) driven by the internal pulse register. When the macro is undefined, the port SHALL NOT exist and pulse SHALL remain an internal register only. Signal behaviour SHALL be identical in both builds.

Verification
REQ-020 Reset scenario: assert reset_n=0 mid-operation -> signal==0 and pulse==0 immediately, without a clock edge.
REQ-021 Bit-0 scenario: release reset with time_data[58]=0 -> pulse high for cycles 0..129999 and low from cycle 130000 of second 0.
REQ-022 Bit-1 scenario: time_data[38]=1 -> pulse high for exactly 260000 cycles starting at cycle 20*1300000 (second 20).
REQ-023 Minute-mark scenario: pulse stays low for all of cycles 76700000..77999999 (second 59). At cycle 78000000, sec==0 and a changed time_data has been latched.
REQ-024 Amplitude scenario: with the default telegram 59'b01001011001110100100100100001000000011101010000010101010001, run 3000000 samples. While pulse is high, |signal| <= 8192; outside reduction, signal peaks within 17 cycles reach >= 32000 and <= 32767.
REQ-025 Config scenario: build with and without DCF_PULSE_PORT_EN -> identical signal sample streams, and the port pulse equals the internal pulse register in every cycle.
